// File: rtl/keypad_scanner.sv
// Row-scanning, snapshot-debouncing front end for the 4x3 safe-lock keypad.
// Optional build macro: KEYPAD_MULTI_KEY_MASK_EN (multi-key snapshots read as no key).
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  col_in,
  output logic [3:0]  row_out,
  output logic [11:0] key,
  output logic        key_change
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS - 1);

  logic [1:0]    row_reg;
  logic [DW-1:0] dwell_reg;
  logic [11:0]   raw_reg;
  logic [11:0]   cand_reg;
  logic [CW-1:0] cnt_reg;
  logic [11:0]   key_reg;
  logic          key_change_reg;

  logic [11:0]   row_sel;
  logic [11:0]   row_samp;
  logic [11:0]   raw_next;
  logic [11:0]   snap;
  logic [CW-1:0] cnt_next;
  logic          last_dwell;
  logic          end_scan;
  logic          accept;

  // Each (row, col) lands on the key bit the encoder expects; the map is a bijection.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_out[gi] = (row_reg != 2'(gi));
      for (gj = 0; gj < 3; gj++) begin : g_col
        localparam int KB = (gi < 3) ? (gi * 3 + gj + 1)
                                     : ((gj == 0) ? 10 : ((gj == 1) ? 0 : 11));
        assign row_sel[KB]  = (row_reg == 2'(gi));
        assign row_samp[KB] = ~col_in[gj];
      end
    end
  endgenerate

  assign last_dwell = (dwell_reg == DWELL_LAST);
  assign end_scan   = last_dwell && (row_reg == 2'd3);
  assign raw_next   = (raw_reg & ~row_sel) | (row_samp & row_sel);

`ifdef KEYPAD_MULTI_KEY_MASK_EN
  assign snap = ((raw_next & (raw_next - 12'd1)) != 12'd0) ? 12'd0 : raw_next;
`else
  assign snap = raw_next;
`endif

  always_comb begin
    cnt_next = '0;
    if (snap == cand_reg) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
    end
  end

  assign accept = end_scan && (cnt_next == CNT_MAX) && (snap != key_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg        <= 2'd0;
      dwell_reg      <= '0;
      raw_reg        <= 12'd0;
      cand_reg       <= 12'd0;
      cnt_reg        <= '0;
      key_reg        <= 12'd0;
      key_change_reg <= 1'b0;
    end else begin
      key_change_reg <= 1'b0;
      if (last_dwell) begin
        dwell_reg <= '0;
        row_reg   <= row_reg + 2'd1;
        raw_reg   <= raw_next;
      end else begin
        dwell_reg <= dwell_reg + DW'(1);
      end
      if (end_scan) begin
        cand_reg <= snap;
        cnt_reg  <= cnt_next;
        if (accept) begin
          key_reg        <= snap;
          key_change_reg <= 1'b1;
        end
      end
    end
  end

  assign key        = key_reg;
  assign key_change = key_change_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad emulation, scan-level reference model and directed scenarios.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  col_in;
  logic [3:0]  row_out;
  logic [11:0] key;
  logic        key_change;

  logic [11:0] pressed = 12'd0;
  int checks = 0;
  int failures = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in),
    .row_out(row_out), .key(key), .key_change(key_change)
  );

  always #5 clk = ~clk;

  function automatic int kb(int r, int c);
    if (r < 3) return r * 3 + c + 1;
    return (c == 0) ? 10 : ((c == 1) ? 0 : 11);
  endfunction

  // Physical keypad: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_out[r] && pressed[kb(r, c)]) col_in[c] = 1'b0;
  end

  // Reference model: scans are time slots; a snapshot is the pressed keys of each row
  // at that row's last dwell cycle; accept once a value has repeated DB scans in a row.
  int          m_t;
  int          m_run;
  logic [11:0] m_snap, m_prev, m_key;
  logic        m_kc;

  function automatic logic [11:0] row_bits(int r, logic [11:0] p);
    logic [11:0] b = 12'd0;
    for (int c = 0; c < 3; c++) if (p[kb(r, c)]) b[kb(r, c)] = 1'b1;
    return b;
  endfunction

  function automatic logic [11:0] scan_s(logic [11:0] acc, logic [11:0] p);
    logic [11:0] s = acc | row_bits(3, p);
`ifdef KEYPAD_MULTI_KEY_MASK_EN
    if ($countones(s) > 1) s = 12'd0;
`endif
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_run <= 0; m_snap <= 12'd0; m_prev <= 12'd0; m_key <= 12'd0; m_kc <= 1'b0;
    end else begin
      m_kc <= 1'b0;
      m_t  <= m_t + 1;
      if (m_t % SD == SD - 1) begin
        if ((m_t / SD) % 4 == 3) begin
          m_snap <= 12'd0;
          m_prev <= scan_s(m_snap, pressed);
          m_run  <= (scan_s(m_snap, pressed) == m_prev) ? m_run + 1 : 1;
          if ((((scan_s(m_snap, pressed) == m_prev) ? m_run + 1 : 1) >= DB) &&
              (scan_s(m_snap, pressed) != m_key)) begin
            m_key <= scan_s(m_snap, pressed);
            m_kc  <= 1'b1;
          end
        end else begin
          m_snap <= m_snap | row_bits((m_t / SD) % 4, pressed);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] exp_row;
    exp_row = 4'b1111 ^ (4'b0001 << ((m_t / SD) % 4));
    checks++;
    if (row_out !== exp_row || key !== m_key || key_change !== m_kc) begin
      failures++;
      $display("FAIL model t=%0d row_out=%b/%b key=%h/%h key_change=%b/%b (got/exp)",
               m_t, row_out, exp_row, key, m_key, key_change, m_kc);
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end else begin
      $display("check %s = %h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [11:0] p);
    @(negedge clk);
    rst_n = 1'b0;
    pressed = p;
    cyc(2);
    chk("reset_row_out", {8'd0, row_out}, 12'h00E);
    chk("reset_key", key, 12'h000);
    chk("reset_key_change", {11'd0, key_change}, 12'h000);
    rst_n = 1'b1;
  endtask

  logic [3:0] row_seq [0:3];

  initial begin
    row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011; row_seq[3] = 4'b0111;

    // Idle scan sequence
    do_reset(12'd0);
    for (int k = 0; k <= 16; k++) begin
      if (k % 4 == 0) chk($sformatf("idle_row_k%0d", k), {8'd0, row_out}, {8'd0, row_seq[(k / 4) % 4]});
      if (k < 16) cyc(1);
    end

    // Hold '5' from reset
    do_reset(12'h020);
    cyc(31);
    chk("five_before", key, 12'h000);
    cyc(1);
    chk("five_key", key, 12'h020);
    chk("five_pulse", {11'd0, key_change}, 12'h001);
    cyc(1);
    chk("five_pulse_end", {11'd0, key_change}, 12'h000);
    cyc(40);
    chk("five_held", key, 12'h020);

    // '0' bouncing for one scan, then steady, then released
    do_reset(12'd0);
    for (int k = 0; k < 16; k++) begin
      pressed = ((k / 3) % 2 == 0) ? 12'h001 : 12'h000;
      cyc(1);
    end
    pressed = 12'h001;
    cyc(31);
    chk("zero_before", key, 12'h000);
    cyc(1);
    chk("zero_key", key, 12'h001);
    chk("zero_pulse", {11'd0, key_change}, 12'h001);
    pressed = 12'h000;
    cyc(31);
    chk("zero_rel_before", key, 12'h001);
    cyc(1);
    chk("zero_rel_key", key, 12'h000);
    chk("zero_rel_pulse", {11'd0, key_change}, 12'h001);

    // '1' and '2' together
    do_reset(12'h006);
    cyc(32);
`ifdef KEYPAD_MULTI_KEY_MASK_EN
    chk("multi_key", key, 12'h000);
    chk("multi_pulse", {11'd0, key_change}, 12'h000);
`else
    chk("multi_key", key, 12'h006);
    chk("multi_pulse", {11'd0, key_change}, 12'h001);
`endif

    // '#' accepted, then reset pulse in the middle of row 2
    do_reset(12'h800);
    cyc(32);
    chk("hash_key", key, 12'h800);
    cyc(9);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_row_out", {8'd0, row_out}, 12'h00E);
    chk("midreset_key", key, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(31);
    chk("hash_re_before", key, 12'h000);
    cyc(1);
    chk("hash_re_key", key, 12'h800);
    chk("hash_re_pulse", {11'd0, key_change}, 12'h001);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
